// File: rtl/bus_arbiter_if.sv
// Shared-bus arbiter signal bundle: requests and resolved bus value in,
// drive enables, owner status and the registered capture out.
interface bus_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] bus;
  logic [3:0]       enable;
  logic             grant_valid;
  logic [1:0]       owner;
  logic [WIDTH-1:0] cap_data;
  logic [1:0]       cap_owner;
  logic             cap_valid;

  // Arbiter side: drives enables and the capture.
  modport master (
    input  req, bus,
    output enable, grant_valid, owner, cap_data, cap_owner, cap_valid
  );

  // Source and driver side: requests, sees grants and captured data.
  modport slave (
    output req, bus,
    input  enable, grant_valid, owner, cap_data, cap_owner, cap_valid
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared 4-source bus.
// It inserts a dead turnaround cycle between owners and caps the hold time
// while others wait. The resolved bus value is registered and tagged with
// its owner.
module bus_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.master bif
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [3:0]       en_q, en_d;
  logic [1:0]       owner_q, owner_d;
  logic [2:0]       hold_q, hold_d;
  logic             gv_q;
  logic [WIDTH-1:0] cap_data_q;
  logic [1:0]       cap_owner_q;
  logic             cap_vld_q;

  logic             win_found;
  logic [1:0]       win_idx;
  logic             others_req;
  logic             own_req;
  logic             capture;

  // Round-robin search from owner+1 up to owner itself. The loop runs from
  // the farthest candidate to the nearest, so the nearest requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = owner_q;
    for (int k = 4; k >= 1; k--) begin
      if (bif.req[owner_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = owner_q + 2'(k);
      end
    end
  end

  assign own_req    = bif.req[owner_q];
  assign others_req = |(bif.req & ~(4'b0001 << owner_q));
  assign capture    = (state_q == GRANT) && own_req;

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE, TURN: begin
        en_d    = 4'b0000;
        state_d = IDLE;
        if (win_found) begin
          state_d = GRANT;
          owner_d = win_idx;
          en_d    = 4'b0001 << win_idx;
          hold_d  = 3'd0;
        end
      end
      GRANT: begin
        if (hold_q != HOLD_LAST) hold_d = hold_q + 3'd1;
        if (!own_req || (hold_q == HOLD_LAST && others_req)) begin
          state_d = TURN;
          en_d    = 4'b0000;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 4'b0000;
      end
    endcase
  end

  // State and arbitration registers. Reset drops enable at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      en_q    <= 4'b0000;
      gv_q    <= 1'b0;
      owner_q <= 2'd3;
      hold_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      gv_q    <= |en_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  // Bus capture: sample the resolved bus while the owner is still requesting.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_data_q  <= '0;
      cap_owner_q <= 2'd0;
      cap_vld_q   <= 1'b0;
    end else begin
      cap_vld_q <= capture;
      if (capture) begin
        cap_data_q  <= bif.bus;
        cap_owner_q <= owner_q;
      end
    end
  end

  assign bif.enable      = en_q;
  assign bif.grant_valid = gv_q;
  assign bif.owner       = owner_q;
  assign bif.cap_data    = cap_data_q;
  assign bif.cap_owner   = cap_owner_q;
  assign bif.cap_valid   = cap_vld_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. It covers reset, single grant and release,
// full rotation, an uncontended long hold with a bus ramp, preemption, and
// reset in mid-grant. A monitor watches the enable invariants.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] prev_en = 4'b0000;

  bus_arbiter_if #(.WIDTH(4)) bif ();

  bus_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariant monitor: at most one enable bit, and no direct handover.
  always @(negedge clk) begin
    if (!reset) begin
      chk("onehot", 32'($countones(bif.enable) <= 1), 32'd1);
      chk("no_direct_handover",
          32'(prev_en != 4'b0 && bif.enable != 4'b0 && prev_en != bif.enable), 32'd0);
    end
    prev_en = bif.enable;
  end

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    bif.req = 4'b0000;
    bif.bus = 4'h0;
    tick();
    tick();
    chk("rst_enable", 32'(bif.enable), 32'h0);
    chk("rst_gv", 32'(bif.grant_valid), 32'h0);
    chk("rst_owner", 32'(bif.owner), 32'h3);
    chk("rst_capv", 32'(bif.cap_valid), 32'h0);
    chk("rst_capd", 32'(bif.cap_data), 32'h0);
    chk("rst_capo", 32'(bif.cap_owner), 32'h0);
    reset = 1'b0;

    // Single request, capture, then release through TURN to IDLE.
    bif.req = 4'b0001;
    bif.bus = 4'hA;
    tick();
    chk("s1_en", 32'(bif.enable), 32'h1);
    chk("s1_gv", 32'(bif.grant_valid), 32'h1);
    chk("s1_owner", 32'(bif.owner), 32'h0);
    chk("s1_capv0", 32'(bif.cap_valid), 32'h0);
    tick();
    chk("s1_capv1", 32'(bif.cap_valid), 32'h1);
    chk("s1_capd", 32'(bif.cap_data), 32'hA);
    chk("s1_capo", 32'(bif.cap_owner), 32'h0);
    bif.req = 4'b0000;
    tick();
    chk("s1_rel_en", 32'(bif.enable), 32'h0);
    chk("s1_rel_capv", 32'(bif.cap_valid), 32'h0);
    chk("s1_rel_gv", 32'(bif.grant_valid), 32'h0);
    tick();
    chk("s1_idle_en", 32'(bif.enable), 32'h0);
    tick();
    chk("s1_idle2_en", 32'(bif.enable), 32'h0);

    // Full contention: 4 grant cycles per owner, one dead cycle between.
    do_reset();
    bif.req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      for (int h = 0; h < 4; h++) begin
        tick();
        chk($sformatf("rr_o%0d_h%0d", o, h), 32'(bif.enable), 32'(4'b0001 << (o % 4)));
      end
      tick();
      chk($sformatf("rr_turn%0d", o), 32'(bif.enable), 32'h0);
    end

    // Lone requester keeps the bus indefinitely; capture follows a ramp.
    bif.req = 4'b0000;
    do_reset();
    bif.req = 4'b0100;
    tick();
    chk("hold_first", 32'(bif.enable), 32'h4);
    for (int i = 0; i < 20; i++) begin
      bif.bus = 4'(i);
      tick();
      chk($sformatf("hold_en%0d", i), 32'(bif.enable), 32'h4);
      chk($sformatf("hold_capv%0d", i), 32'(bif.cap_valid), 32'h1);
      chk($sformatf("hold_capd%0d", i), 32'(bif.cap_data), 32'(i % 16));
    end
    bif.req = 4'b0000;
    tick();
    tick();

    // Preemption: source 1 owns; source 3 arrives at hold_cnt=1.
    do_reset();
    bif.req = 4'b0010;
    bif.bus = 4'h5;
    tick();
    chk("pre_h0", 32'(bif.enable), 32'h2);
    tick();
    chk("pre_h1", 32'(bif.enable), 32'h2);
    bif.req = 4'b1010;
    tick();
    chk("pre_h2", 32'(bif.enable), 32'h2);
    tick();
    chk("pre_h3", 32'(bif.enable), 32'h2);
    chk("pre_capo1", 32'(bif.cap_owner), 32'h1);
    tick();
    chk("pre_turn", 32'(bif.enable), 32'h0);
    chk("pre_turn_capo", 32'(bif.cap_owner), 32'h1);
    bif.bus = 4'h9;
    tick();
    chk("pre_new", 32'(bif.enable), 32'h8);
    chk("pre_new_owner", 32'(bif.owner), 32'h3);
    chk("pre_new_capv", 32'(bif.cap_valid), 32'h0);
    tick();
    chk("pre_capv3", 32'(bif.cap_valid), 32'h1);
    chk("pre_capo3", 32'(bif.cap_owner), 32'h3);
    chk("pre_capd3", 32'(bif.cap_data), 32'h9);

    // Reset during GRANT drops enable at once; source 0 is granted first after.
    bif.req = 4'b0000;
    tick();
    do_reset();
    bif.req = 4'b1111;
    tick();
    tick();
    tick();
    chk("mid_pre_en", 32'(bif.enable), 32'h1);
    reset = 1'b1;
    tick();
    chk("mid_rst_en", 32'(bif.enable), 32'h0);
    chk("mid_rst_capv", 32'(bif.cap_valid), 32'h0);
    chk("mid_rst_gv", 32'(bif.grant_valid), 32'h0);
    chk("mid_rst_owner", 32'(bif.owner), 32'h3);
    reset = 1'b0;
    tick();
    chk("mid_after_en", 32'(bif.enable), 32'h1);
    chk("mid_after_owner", 32'(bif.owner), 32'h0);

    bif.req = 4'b0000;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
